// File: rtl/picomem_mux_1_n.sv
// picomem_mux_1_n: registered 1-master/N-slave PicoMem decoder; unmapped accesses answer ERR_DATA.
// Optional slave-stall timeout is enabled by defining PICOMEM_MUX_TIMEOUT_EN.
module picomem_mux_1_n #(
  parameter int unsigned            N_SLAVES       = 4,
  parameter logic [32*N_SLAVES-1:0] ADDR_BASE      = {32'h8300_0000, 32'h8200_0000,
                                                      32'h8100_0000, 32'h8000_0000},
  parameter logic [32*N_SLAVES-1:0] ADDR_MASK      = {4{32'hFF00_0000}},
  parameter logic [31:0]            ERR_DATA       = 32'hDEAD_BEEF,
  parameter int unsigned            TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     picom_valid,
  output logic                     picom_ready,
  input  logic [31:0]              picom_addr,
  input  logic [31:0]              picom_wdata,
  input  logic [3:0]               picom_wstrb,
  output logic [31:0]              picom_rdata,
  output logic [N_SLAVES-1:0]      picos_valid,
  input  logic [N_SLAVES-1:0]      picos_ready,
  output logic [32*N_SLAVES-1:0]   picos_addr,
  output logic [32*N_SLAVES-1:0]   picos_wdata,
  output logic [4*N_SLAVES-1:0]    picos_wstrb,
  input  logic [32*N_SLAVES-1:0]   picos_rdata,
  output logic                     err_valid,
  output logic [31:0]              err_addr
);

  localparam int unsigned SEL_W     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [N_SLAVES-1:0] valid_q, valid_d;
  logic [N_SLAVES-1:0] sel_oh_q, sel_oh_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic [N_SLAVES-1:0] hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                hit_any;
  logic                sel_ready;
  logic [31:0]         sel_rdata;

`ifdef PICOMEM_MUX_TIMEOUT_EN
  logic [15:0]         cnt_q, cnt_d;
`else
  logic                unused_tmo;
  assign unused_tmo = ^TMO_LIMIT;
`endif

  // Lowest-index window wins when windows overlap.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      hit[i] = (addr_q & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32];
      if (hit[i] && !hit_any) begin
        hit_idx = SEL_W'(i);
        hit_any = 1'b1;
      end
    end
  end

  assign sel_ready = picos_ready[sel_q];
  assign sel_rdata = picos_rdata[32*sel_q +: 32];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    valid_d    = valid_q;
    sel_oh_d   = sel_oh_q;
    sel_d      = sel_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
`ifdef PICOMEM_MUX_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        sel_oh_d = '0;
        if (picom_valid && !ready_q) begin
          addr_d  = picom_addr;
          wdata_d = picom_wdata;
          wstrb_d = picom_wstrb;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (hit_any) begin
          sel_d             = hit_idx;
          sel_oh_d          = '0;
          sel_oh_d[hit_idx] = 1'b1;
          valid_d           = '0;
          valid_d[hit_idx]  = 1'b1;
`ifdef PICOMEM_MUX_TIMEOUT_EN
          cnt_d             = '0;
`endif
          state_d           = S_ACCESS;
        end else begin
          rdata_d    = ERR_DATA;
          err_addr_d = addr_q;
          err_d      = 1'b1;
          ready_d    = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_ACCESS: begin
        // A ready arriving on the expiry cycle takes priority over the timeout.
        if (sel_ready) begin
          valid_d = '0;
          rdata_d = sel_rdata;
          ready_d = 1'b1;
          state_d = S_RESP;
        end
`ifdef PICOMEM_MUX_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TMO_LIMIT) begin
          valid_d    = '0;
          rdata_d    = ERR_DATA;
          err_addr_d = addr_q;
          err_d      = 1'b1;
          ready_d    = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      valid_q    <= '0;
      sel_oh_q   <= '0;
      sel_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef PICOMEM_MUX_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      valid_q    <= valid_d;
      sel_oh_q   <= sel_oh_d;
      sel_q      <= sel_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
`ifdef PICOMEM_MUX_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    picos_wstrb = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      picos_wstrb[4*i +: 4] = sel_oh_q[i] ? wstrb_q : 4'b0000;
    end
  end

  assign picom_ready = ready_q;
  assign picom_rdata = rdata_q;
  assign picos_valid = valid_q;
  assign picos_addr  = {N_SLAVES{addr_q}};
  assign picos_wdata = {N_SLAVES{wdata_q}};
  assign err_valid   = err_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_picomem_mux_1_n.sv
// Bench for picomem_mux_1_n: randomized master traffic against memory-backed slaves,
// checked every cycle against a transaction-level timing/data model.
module tb_picomem_mux_1_n;

  localparam int TMO = 8;
`ifdef PICOMEM_MUX_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam logic [31:0] BASE [4] = '{32'h8000_0000, 32'h8100_0000, 32'h8200_0000, 32'h8300_0000};
  localparam logic [31:0] MASK = 32'hFF00_0000;

  logic         clk = 1'b0;
  logic         resetn;
  logic         picom_valid;
  logic         picom_ready;
  logic [31:0]  picom_addr, picom_wdata, picom_rdata;
  logic [3:0]   picom_wstrb;
  logic [3:0]   picos_valid, picos_ready;
  logic [127:0] picos_addr, picos_wdata, picos_rdata;
  logic [15:0]  picos_wstrb;
  logic         err_valid;
  logic [31:0]  err_addr;

  picomem_mux_1_n #(
    .N_SLAVES      (4),
    .ADDR_BASE     ({32'h8300_0000, 32'h8200_0000, 32'h8100_0000, 32'h8000_0000}),
    .ADDR_MASK     ({4{32'hFF00_0000}}),
    .ERR_DATA      (32'hDEAD_BEEF),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .picom_valid(picom_valid),
    .picom_ready(picom_ready),
    .picom_addr (picom_addr),
    .picom_wdata(picom_wdata),
    .picom_wstrb(picom_wstrb),
    .picom_rdata(picom_rdata),
    .picos_valid(picos_valid),
    .picos_ready(picos_ready),
    .picos_addr (picos_addr),
    .picos_wdata(picos_wdata),
    .picos_wstrb(picos_wstrb),
    .picos_rdata(picos_rdata),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          chk_en   = 1'b0;

  // slave side (stimulus)
  logic [31:0] smem [4][16];
  int unsigned vcnt [4] = '{default: 0};
  int unsigned wcfg [4] = '{default: 0};
  logic [3:0]  noise = 4'b0;

  // reference model
  logic [31:0] mmem [4][16];
  int          exp_vs = -100, exp_ve = -100, exp_rc = -100, exp_sel = 0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [31:0] hold_rd = '0, hold_ea = '0;
  int          last_rdy = -1;
  int          n_errp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if ((a & MASK) == BASE[i]) return i;
    return -1;
  endfunction

  always_comb begin
    picos_ready = '0;
    picos_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      picos_ready[i] = picos_valid[i] ? (vcnt[i] >= wcfg[i]) : noise[i];
      picos_rdata[32*i +: 32] = smem[i][picos_addr[32*i+2 +: 4]];
    end
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      vcnt[i] <= picos_valid[i] ? vcnt[i] + 1 : 0;
      if (cyc == 0) begin
        for (int j = 0; j < 16; j++) smem[i][j] <= (i == 2 && j == 4) ? 32'h1234_5678 : 32'h0;
      end else if (picos_valid[i] && picos_ready[i]) begin
        for (int b = 0; b < 4; b++)
          if (picos_wstrb[4*i+b])
            smem[i][picos_addr[32*i+2 +: 4]][8*b +: 8] <= picos_wdata[32*i+8*b +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (!chk_en) begin
      hold_rd <= '0;
      hold_ea <= '0;
    end else begin
      logic [3:0]  ev;
      logic [31:0] want_rd, want_ea;
      bit          at_rc;
      at_rc   = (cyc == exp_rc);
      ev      = (cyc >= exp_vs && cyc <= exp_ve) ? 4'(1 << exp_sel) : 4'b0000;
      want_rd = at_rc ? exp_rdata : hold_rd;
      want_ea = (at_rc && exp_err) ? exp_addr : hold_ea;
      chk("picos_valid", 32'(picos_valid), 32'(ev));
      chk("picom_ready", 32'(picom_ready), 32'(at_rc));
      chk("err_valid", 32'(err_valid), 32'(at_rc && exp_err));
      chk("picom_rdata", picom_rdata, want_rd);
      chk("err_addr", err_addr, want_ea);
      if (ev != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          chk("picos_addr", picos_addr[32*i +: 32], exp_addr);
          chk("picos_wdata", picos_wdata[32*i +: 32], exp_wdata);
          chk("picos_wstrb", 32'(picos_wstrb[4*i +: 4]), 32'((i == exp_sel) ? exp_wstrb : 4'b0000));
        end
      end
      if (picom_ready) last_rdy <= cyc;
      if (err_valid) n_errp <= n_errp + 1;
      hold_rd <= want_rd;
      hold_ea <= want_ea;
    end
  end

  // One master transaction; returns at the negedge of the response cycle.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int unsigned w, output int t0, output bit err);
    int s;
    int idx;
    s   = decode(a);
    idx = int'(a[5:2]);
    err = 1'b0;
    @(negedge clk);
    t0 = cyc;
    exp_addr  = a;
    exp_wdata = wd;
    exp_wstrb = ws;
    if (s < 0) begin
      exp_vs = -100; exp_ve = -100; exp_rc = t0 + 2; err = 1'b1;
    end else begin
      wcfg[s] = w;
      exp_sel = s;
      exp_vs  = t0 + 2;
      if (TMO_ON && w >= TMO) begin
        exp_ve = t0 + 1 + TMO; exp_rc = t0 + 2 + TMO; err = 1'b1;
      end else begin
        exp_ve = t0 + 2 + int'(w); exp_rc = t0 + 3 + int'(w);
      end
    end
    exp_err = err;
    if (err) exp_rdata = 32'hDEAD_BEEF;
    else     exp_rdata = mmem[s][idx];
    picom_valid = 1'b1;
    picom_addr  = a;
    picom_wdata = wd;
    picom_wstrb = ws;
    @(negedge clk);
    picom_addr  = $urandom;
    picom_wdata = $urandom;
    picom_wstrb = 4'($urandom);
    repeat (exp_rc - t0 - 1) @(negedge clk);
    picom_valid = 1'b0;
    if (!err && ws != 4'b0000)
      for (int b = 0; b < 4; b++) if (ws[b]) mmem[s][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    int t0;
    int e0;
    bit err;
    logic [31:0] a;
    int unsigned w;
    logic [3:0] ws;
    resetn      = 1'b0;
    picom_valid = 1'b0;
    picom_addr  = '0;
    picom_wdata = '0;
    picom_wstrb = '0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) mmem[i][j] = '0;
    mmem[2][4] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(picom_ready), 32'h0);
    chk("rst_rdata", picom_rdata, 32'h0);
    chk("rst_valid", 32'(picos_valid), 32'h0);
    chk("rst_err_valid", 32'(err_valid), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_addr", picos_addr[31:0], 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk_en = 1'b1;

    // read slot 2, zero wait
    e0 = n_errp;
    txn(32'h8200_0010, 32'h0, 4'b0000, 0, t0, err);
    #1;
    chk("rd2_data", picom_rdata, 32'h1234_5678);
    chk("rd2_latency", 32'(last_rdy - t0 + 1), 32'd4);
    chk("rd2_no_err", 32'(n_errp - e0), 32'd0);

    // write slot 1, three wait cycles
    txn(32'h8100_0004, 32'hA5A5_5A5A, 4'b0011, 3, t0, err);
    #1;
    chk("wr1_latency", 32'(last_rdy - t0 + 1), 32'd7);
    chk("wr1_mem", smem[1][1], 32'h0000_5A5A);

    // unmapped read
    e0 = n_errp;
    txn(32'h9000_0000, 32'h0, 4'b0000, 0, t0, err);
    #1;
    chk("unm_data", picom_rdata, 32'hDEAD_BEEF);
    chk("unm_err_addr", err_addr, 32'h9000_0000);
    chk("unm_latency", 32'(last_rdy - t0 + 1), 32'd3);
    chk("unm_err_pulse", 32'(n_errp - e0), 32'd1);

`ifdef PICOMEM_MUX_TIMEOUT_EN
    e0 = n_errp;
    txn(32'h8300_0040, 32'h0, 4'b0000, 1000, t0, err);
    #1;
    chk("tmo_data", picom_rdata, 32'hDEAD_BEEF);
    chk("tmo_latency", 32'(last_rdy - t0 + 1), 32'd11);
    chk("tmo_err_pulse", 32'(n_errp - e0), 32'd1);
    e0 = n_errp;
    txn(32'h8300_0040, 32'h0, 4'b0000, 7, t0, err);
    #1;
    chk("tie_latency", 32'(last_rdy - t0 + 1), 32'd11);
    chk("tie_no_err", 32'(n_errp - e0), 32'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom;
        a[31:24] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'h7F))
                                               : 8'($urandom_range(8'h84, 8'hFF));
      end else begin
        a = BASE[$urandom_range(0, 3)] | (32'($urandom) & 32'h00FF_FFFF);
      end
      ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      w  = $urandom_range(0, 5);
      if (TMO_ON && $urandom_range(0, 9) == 0) w = $urandom_range(TMO - 1, TMO + 4);
      txn(a, $urandom, ws, w, t0, err);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset while a slot-0 access is stalled
    @(negedge clk);
    t0 = cyc;
    wcfg[0]   = 1000;
    exp_sel   = 0;
    exp_addr  = 32'h8000_0020;
    exp_wdata = 32'h0;
    exp_wstrb = 4'b0000;
    exp_rc    = -100;
    exp_vs    = t0 + 2;
    exp_ve    = 1 << 30;
    picom_valid = 1'b1;
    picom_addr  = 32'h8000_0020;
    picom_wdata = 32'h0;
    picom_wstrb = 4'b0000;
    repeat (4) @(negedge clk);
    #1 chk("mid_valid", 32'(picos_valid), 32'h1);
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(picos_valid), 32'h0);
    chk("arst_ready", 32'(picom_ready), 32'h0);
    chk("arst_rdata", picom_rdata, 32'h0);
    chk("arst_err_addr", err_addr, 32'h0);
    chk("arst_wstrb", 32'(picos_wstrb), 32'h0);
    chk("arst_addr", picos_addr[31:0], 32'h0);
    picom_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    exp_vs = -100;
    exp_ve = -100;
    #1 chk_en = 1'b1;

    txn(32'h8000_0024, 32'h0, 4'b0000, 2, t0, err);
    #1;
    chk("post_rst_data", picom_rdata, mmem[0][9]);
    chk("post_rst_latency", 32'(last_rdy - t0 + 1), 32'd6);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
